// File: rtl/fetch_pkg.sv
// Shared definitions for the bytecode fetch stage: FSM states, argument-count
// encodings and the NOP opcode used as the idle opcode value.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_OP,
    LATCH_OP,
    DECODE,
    ARG2,
    ISSUE,
    HALT
  } fetch_state_t;

  localparam logic [1:0] ARGC_0 = 2'd0;
  localparam logic [1:0] ARGC_1 = 2'd1;
  localparam logic [1:0] ARGC_2 = 2'd2;
  localparam logic [1:0] ARGC_3 = 2'd3;

  localparam logic [7:0] OP_NOP = 8'h00;

  // The decoder never legitimately reports 3; such opcodes are treated as two-argument.
  function automatic logic [1:0] argc_clamp(input logic [1:0] a);
    return (a == ARGC_3) ? ARGC_2 : a;
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Bytecode fetch stage: reads opcode plus 0-2 argument bytes from 1-cycle-latency
// program memory, sizes the instruction from decoder argc, and issues it to execute.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_rdata,
  output logic [7:0]            opcode,
  input  logic [1:0]            argc,
  output logic [7:0]            arg1,
  output logic [7:0]            arg2,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  jump_en,
  input  logic [15:0]           jump_offset,
  input  logic                  halt_req,
  output logic                  halted
);

  localparam int OW = (ADDR_WIDTH > 16) ? ADDR_WIDTH : 16;

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [1:0]            argn;
  logic [1:0]            argc_eff;
  logic [OW-1:0]         offset_ext;
  logic [ADDR_WIDTH-1:0] jump_pc;
  logic [ADDR_WIDTH-1:0] seq_pc;

  assign argc_eff   = argc_clamp(argc);
  // Branch offsets are relative to the opcode byte and wrap with the PC.
  assign offset_ext = OW'($signed(jump_offset));
  assign jump_pc    = pc + offset_ext[ADDR_WIDTH-1:0];
  assign seq_pc     = pc + ADDR_WIDTH'(argn) + ADDR_WIDTH'(1);

  always_comb begin
    mem_addr = pc;
    case (state)
      IDLE:         mem_addr = '0;
      LATCH_OP:     mem_addr = pc + ADDR_WIDTH'(1);
      DECODE, ARG2: mem_addr = pc + ADDR_WIDTH'(2);
      default:      mem_addr = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= '0;
      argn        <= ARGC_0;
      opcode      <= OP_NOP;
      arg1        <= 8'h00;
      arg2        <= 8'h00;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pc    <= '0;
            state <= FETCH_OP;
          end
        end
        FETCH_OP: state <= LATCH_OP;
        LATCH_OP: begin
          opcode <= mem_rdata;
          arg1   <= 8'h00;
          arg2   <= 8'h00;
          state  <= DECODE;
        end
        DECODE: begin
          argn <= argc_eff;
          if (argc_eff != ARGC_0) arg1 <= mem_rdata;
          if (argc_eff == ARGC_2) begin
            state <= ARG2;
          end else begin
            instr_valid <= 1'b1;
            instr_pc    <= pc;
            state       <= ISSUE;
          end
        end
        ARG2: begin
          arg2        <= mem_rdata;
          instr_valid <= 1'b1;
          instr_pc    <= pc;
          state       <= ISSUE;
        end
        ISSUE: begin
          // instr_valid is always high here, so ready alone marks the transfer.
          if (instr_ready) begin
            instr_valid <= 1'b0;
            if (halt_req) begin
              halted <= 1'b1;
              state  <= HALT;
            end else begin
              pc    <= jump_en ? jump_pc : seq_pc;
              state <= FETCH_OP;
            end
          end
        end
        HALT:    halted <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a small opcode->argc decoder model and a
// 1-cycle-latency byte ROM; each task covers one scenario with inline checks.
module tb_instr_fetch;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic [7:0]    opcode;
  logic [1:0]    argc;
  logic [7:0]    arg1;
  logic [7:0]    arg2;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic          jump_en;
  logic [15:0]   jump_offset;
  logic          halt_req;
  logic          halted;

  logic [7:0] rom [0:4095];

  int errors = 0;
  int checks = 0;

  instr_fetch #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .opcode(opcode), .argc(argc), .arg1(arg1), .arg2(arg2), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .jump_en(jump_en),
    .jump_offset(jump_offset), .halt_req(halt_req), .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= rom[mem_addr];

  always_comb begin
    argc = 2'd0;
    case (opcode)
      8'h10:        argc = 2'd1;
      8'h11, 8'hA7: argc = 2'd2;
      8'hFF:        argc = 2'd3;
      default:      argc = 2'd0;
    endcase
  end

  task automatic clear_rom;
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset;
    rst = 1'b1; start = 1'b0; instr_ready = 1'b0;
    jump_en = 1'b0; halt_req = 1'b0; jump_offset = 16'h0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Pulses start and returns the number of cycles until instr_valid, or -1.
  task automatic start_and_wait(output int cyc);
    @(negedge clk);
    start = 1'b1;
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (instr_valid) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic wait_valid(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; instr_ready = 1'b0;
    jump_en = 1'b0; halt_req = 1'b0; jump_offset = 16'h0000;
    clear_rom();
    repeat (2) @(negedge clk);
    checks++;
    if ({instr_valid, halted, opcode, arg1, arg2, instr_pc, mem_addr} !== 50'h0) begin
      errors++;
      $display("FAIL reset_values got=%h exp=%h", {instr_valid, halted, opcode, arg1, arg2, instr_pc, mem_addr}, 50'h0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({instr_valid, mem_addr} !== 13'h0) begin
      errors++;
      $display("FAIL idle_no_start got valid=%b addr=%h exp valid=0 addr=000", instr_valid, mem_addr);
    end
    $display("test_reset done");
  endtask

  task automatic test_sequential;
    int cyc;
    clear_rom();
    rom[0] = 8'h04; rom[1] = 8'h10; rom[2] = 8'h2A;
    do_reset();
    instr_ready = 1'b1;
    start_and_wait(cyc);
    checks++;
    if (cyc !== 4) begin errors++; $display("FAIL seq_latency0 got=%0d exp=4", cyc); end
    checks++;
    if ({opcode, arg1, arg2, instr_pc} !== {8'h04, 8'h00, 8'h00, 12'h000}) begin
      errors++; $display("FAIL seq_issue0 got=%h exp=%h", {opcode, arg1, arg2, instr_pc}, {8'h04, 8'h00, 8'h00, 12'h000});
    end
    @(negedge clk);
    checks++;
    if ({instr_valid, mem_addr} !== {1'b0, 12'h001}) begin
      errors++; $display("FAIL seq_next_pc0 got valid=%b addr=%h exp valid=0 addr=001", instr_valid, mem_addr);
    end
    wait_valid(cyc);
    checks++;
    if ({opcode, arg1, arg2, instr_pc} !== {8'h10, 8'h2A, 8'h00, 12'h001}) begin
      errors++; $display("FAIL seq_issue1 got=%h exp=%h (cyc=%0d)", {opcode, arg1, arg2, instr_pc}, {8'h10, 8'h2A, 8'h00, 12'h001}, cyc);
    end
    @(negedge clk);
    instr_ready = 1'b0;
    checks++;
    if (mem_addr !== 12'h003) begin errors++; $display("FAIL seq_next_pc1 got=%h exp=003", mem_addr); end
    $display("test_sequential done");
  endtask

  task automatic test_two_args;
    int cyc;
    clear_rom();
    rom[0] = 8'h11; rom[1] = 8'h01; rom[2] = 8'h2C;
    do_reset();
    start_and_wait(cyc);
    checks++;
    if (cyc !== 5) begin errors++; $display("FAIL sipush_latency got=%0d exp=5", cyc); end
    checks++;
    if ({opcode, arg1, arg2, instr_pc} !== {8'h11, 8'h01, 8'h2C, 12'h000}) begin
      errors++; $display("FAIL sipush_issue got=%h exp=%h", {opcode, arg1, arg2, instr_pc}, {8'h11, 8'h01, 8'h2C, 12'h000});
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    checks++;
    if (mem_addr !== 12'h003) begin errors++; $display("FAIL sipush_next_pc got=%h exp=003", mem_addr); end
    $display("test_two_args done");
  endtask

  task automatic test_illegal_argc;
    int cyc;
    clear_rom();
    rom[0] = 8'hFF; rom[1] = 8'h11; rom[2] = 8'h22; rom[3] = 8'h04;
    do_reset();
    start_and_wait(cyc);
    checks++;
    if (cyc !== 5 || {opcode, arg1, arg2} !== {8'hFF, 8'h11, 8'h22}) begin
      errors++; $display("FAIL argc3_issue got cyc=%0d %h exp cyc=5 ff1122", cyc, {opcode, arg1, arg2});
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    checks++;
    if (mem_addr !== 12'h003) begin errors++; $display("FAIL argc3_next_pc got=%h exp=003", mem_addr); end
    $display("test_illegal_argc done");
  endtask

  task automatic test_branch;
    int cyc;
    clear_rom();
    rom[12'h000] = 8'hA7; rom[12'h001] = 8'h00; rom[12'h002] = 8'h10;
    rom[12'h010] = 8'hA7; rom[12'h011] = 8'hFF; rom[12'h012] = 8'hF0;
    do_reset();
    start_and_wait(cyc);
    jump_en = 1'b1; jump_offset = 16'h0010; instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0; jump_en = 1'b0;
    checks++;
    if (mem_addr !== 12'h010) begin errors++; $display("FAIL br_fwd16 got=%h exp=010", mem_addr); end
    wait_valid(cyc);
    checks++;
    if ({opcode, arg1, arg2, instr_pc} !== {8'hA7, 8'hFF, 8'hF0, 12'h010}) begin
      errors++; $display("FAIL br_issue_at10 got=%h exp=%h", {opcode, arg1, arg2, instr_pc}, {8'hA7, 8'hFF, 8'hF0, 12'h010});
    end
    jump_en = 1'b1; jump_offset = 16'hFFF0; instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0; jump_en = 1'b0;
    checks++;
    if (mem_addr !== 12'h000) begin errors++; $display("FAIL br_back16 got=%h exp=000", mem_addr); end
    wait_valid(cyc);
    jump_en = 1'b1; jump_offset = 16'h0010; instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0; jump_en = 1'b0;
    wait_valid(cyc);
    checks++;
    if (instr_pc !== 12'h010) begin errors++; $display("FAIL br_return_to10 got=%h exp=010", instr_pc); end
    jump_en = 1'b1; jump_offset = 16'h0005; instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0; jump_en = 1'b0;
    checks++;
    if (mem_addr !== 12'h015) begin errors++; $display("FAIL br_fwd5 got=%h exp=015", mem_addr); end
    $display("test_branch done");
  endtask

  task automatic test_backpressure;
    int cyc;
    clear_rom();
    rom[0] = 8'h10; rom[1] = 8'h2A; rom[2] = 8'h00;
    do_reset();
    start_and_wait(cyc);
    checks++;
    if (cyc !== 4) begin errors++; $display("FAIL bp_latency got=%0d exp=4", cyc); end
    halt_req = 1'b1; jump_en = 1'b1; jump_offset = 16'h0100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({instr_valid, halted, opcode, arg1, arg2, instr_pc, mem_addr} !==
          {1'b1, 1'b0, 8'h10, 8'h2A, 8'h00, 12'h000, 12'h000}) begin
        errors++; $display("FAIL bp_stall%0d got=%h exp=%h", i, {instr_valid, halted, opcode, arg1, arg2, instr_pc, mem_addr},
                           {1'b1, 1'b0, 8'h10, 8'h2A, 8'h00, 12'h000, 12'h000});
      end
    end
    halt_req = 1'b0; jump_en = 1'b0; instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    checks++;
    if ({instr_valid, mem_addr} !== {1'b0, 12'h002}) begin
      errors++; $display("FAIL bp_release got valid=%b addr=%h exp valid=0 addr=002", instr_valid, mem_addr);
    end
    wait_valid(cyc);
    checks++;
    if ({opcode, instr_pc} !== {8'h00, 12'h002}) begin
      errors++; $display("FAIL bp_single_xfer got=%h exp=%h", {opcode, instr_pc}, {8'h00, 12'h002});
    end
    $display("test_backpressure done");
  endtask

  task automatic test_wrap_halt;
    int cyc;
    clear_rom();
    rom[12'h000] = 8'hA7; rom[12'h001] = 8'hFF; rom[12'h002] = 8'hFF;
    do_reset();
    start_and_wait(cyc);
    jump_en = 1'b1; jump_offset = 16'hFFFF; instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0; jump_en = 1'b0;
    checks++;
    if (mem_addr !== 12'hFFF) begin errors++; $display("FAIL wrap_jump_neg1 got=%h exp=fff", mem_addr); end
    wait_valid(cyc);
    checks++;
    if ({opcode, instr_pc} !== {8'h00, 12'hFFF}) begin
      errors++; $display("FAIL wrap_issue_fff got=%h exp=%h", {opcode, instr_pc}, {8'h00, 12'hFFF});
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    checks++;
    if (mem_addr !== 12'h000) begin errors++; $display("FAIL wrap_seq got=%h exp=000", mem_addr); end
    wait_valid(cyc);
    halt_req = 1'b1; jump_en = 1'b1; jump_offset = 16'h0100; instr_ready = 1'b1;
    @(negedge clk);
    halt_req = 1'b0; jump_en = 1'b0; instr_ready = 1'b0;
    checks++;
    if ({halted, instr_valid} !== 2'b10) begin
      errors++; $display("FAIL halt_enter got halted=%b valid=%b exp halted=1 valid=0", halted, instr_valid);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({halted, instr_valid, mem_addr} !== {1'b1, 1'b0, 12'h000}) begin
      errors++; $display("FAIL halt_sticky got=%h exp=%h", {halted, instr_valid, mem_addr}, {1'b1, 1'b0, 12'h000});
    end
    $display("test_wrap_halt done");
  endtask

  task automatic test_reset_midflight;
    int cyc;
    clear_rom();
    rom[0] = 8'h11; rom[1] = 8'h01; rom[2] = 8'h2C;
    do_reset();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({instr_valid, halted, opcode, arg1, arg2, instr_pc, mem_addr} !== 50'h0) begin
      errors++; $display("FAIL rst_in_arg2 got=%h exp=%h", {instr_valid, halted, opcode, arg1, arg2, instr_pc, mem_addr}, 50'h0);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({instr_valid, mem_addr} !== 13'h0) begin
      errors++; $display("FAIL rst_back_idle got valid=%b addr=%h exp valid=0 addr=000", instr_valid, mem_addr);
    end
    start_and_wait(cyc);
    checks++;
    if (cyc !== 5) begin errors++; $display("FAIL rst_restart got=%0d exp=5", cyc); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({instr_valid, halted, opcode, arg1, arg2, instr_pc, mem_addr} !== 50'h0) begin
      errors++; $display("FAIL rst_in_issue got=%h exp=%h", {instr_valid, halted, opcode, arg1, arg2, instr_pc, mem_addr}, 50'h0);
    end
    rst = 1'b0;
    $display("test_reset_midflight done");
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_two_args();
    test_illegal_argc();
    test_branch();
    test_backpressure();
    test_wrap_halt();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
